// File: rtl/pipe_cmd_decoder_if.sv
// Pipe command decoder bus bundle.
// Groups the pipe-in FIFO read port, the register write port and the packet
// status outputs so the decoder and its environment connect through one port.
//   master : decoder side (drives fifo_rdreq, reg_wr_*, pkt_*, err_code, pkt_count)
//   slave  : environment side (drives fifo_empty, fifo_q)
interface pipe_cmd_decoder_if;
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic [31:0] fifo_q;
  logic        reg_wr_en;
  logic [7:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic        pkt_done;
  logic        pkt_err;
  logic [2:0]  err_code;
  logic [15:0] pkt_count;

  modport master (
    input  fifo_empty, fifo_q,
    output fifo_rdreq, reg_wr_en, reg_wr_addr, reg_wr_data,
           pkt_done, pkt_err, err_code, pkt_count
  );

  modport slave (
    output fifo_empty, fifo_q,
    input  fifo_rdreq, reg_wr_en, reg_wr_addr, reg_wr_data,
           pkt_done, pkt_err, err_code, pkt_count
  );
endinterface

// File: rtl/pipe_cmd_decoder.sv
// Pipe command decoder.
// Pulls packets (header, N payload words, checksum) out of a normal-mode FIFO
// and turns each payload word into a register write at consecutive addresses.
// Ports:
//   okClk  : clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : pipe_cmd_decoder_if.master (FIFO read port, register write port,
//            pkt_done/pkt_err pulses, err_code, pkt_count)
//
// state   | meaning
// --------+-----------------------------------------------------------
// HUNT    | reading one word at a time looking for a valid header
// PAYLOAD | streaming payload words out as register writes
// CHECK   | waiting for the checksum word
module pipe_cmd_decoder #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 1024
) (
  input logic                okClk,
  input logic                reset,
  pipe_cmd_decoder_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

  state_t      state, state_nxt;
  logic        q_valid;
  logic        rd_req;
  logic        tmo_hit;
  logic [8:0]  budget, budget_nxt;
  logic [7:0]  pay_cnt, pay_cnt_nxt;
  logic [7:0]  ptr, ptr_nxt;
  logic [31:0] acc, acc_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;

  logic        wr_en_q, wr_en_nxt;
  logic [7:0]  wr_addr_q, wr_addr_nxt;
  logic [31:0] wr_data_q, wr_data_nxt;
  logic        done_q, done_nxt;
  logic        err_q, err_nxt;
  logic [2:0]  code_q, code_nxt;
  logic [15:0] cnt_q, cnt_nxt;

  always_comb begin
    state_nxt   = state;
    budget_nxt  = budget;
    pay_cnt_nxt = pay_cnt;
    ptr_nxt     = ptr;
    acc_nxt     = acc;
    tmo_nxt     = tmo_cnt;
    rd_req      = 1'b0;
    tmo_hit     = 1'b0;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr_q;
    wr_data_nxt = wr_data_q;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    code_nxt    = code_q;
    cnt_nxt     = cnt_q;

    case (state)
      HUNT: begin
        // One header read at a time so a payload word is never fetched
        // before the header has been judged.
        rd_req = !bus.fifo_empty && !q_valid;
        if (q_valid) begin
          if (bus.fifo_q[31:24] != SYNC) begin
            err_nxt  = 1'b1;
            code_nxt = 3'd1;
          end else if (bus.fifo_q[7:0] == 8'd0) begin
            err_nxt  = 1'b1;
            code_nxt = 3'd2;
          end else begin
            ptr_nxt     = bus.fifo_q[23:16];
            acc_nxt     = bus.fifo_q;
            budget_nxt  = {1'b0, bus.fifo_q[7:0]} + 9'd1;
            pay_cnt_nxt = bus.fifo_q[7:0];
            tmo_nxt     = '0;
            state_nxt   = PAYLOAD;
          end
        end
      end

      PAYLOAD, CHECK: begin
        if (q_valid)
          tmo_nxt = '0;
        else if (tmo_cnt == TW'(TIMEOUT - 1))
          tmo_hit = 1'b1;
        else
          tmo_nxt = tmo_cnt + TW'(1);

        // No fresh read on the abort cycle, otherwise its data would land in
        // HUNT and be mistaken for a header.
        rd_req = !bus.fifo_empty && (budget != 9'd0) && !tmo_hit;
        if (rd_req)
          budget_nxt = budget - 9'd1;

        if (tmo_hit) begin
          err_nxt    = 1'b1;
          code_nxt   = 3'd4;
          budget_nxt = '0;
          tmo_nxt    = '0;
          state_nxt  = HUNT;
        end else if (q_valid) begin
          if (state == PAYLOAD) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = ptr;
            wr_data_nxt = bus.fifo_q;
            ptr_nxt     = ptr + 8'd1;
            acc_nxt     = acc ^ bus.fifo_q;
            pay_cnt_nxt = pay_cnt - 8'd1;
            if (pay_cnt == 8'd1)
              state_nxt = CHECK;
          end else begin
            if (bus.fifo_q == acc) begin
              done_nxt = 1'b1;
              cnt_nxt  = cnt_q + 16'd1;
            end else begin
              err_nxt  = 1'b1;
              code_nxt = 3'd3;
            end
            state_nxt = HUNT;
          end
        end
      end

      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge okClk) begin
    if (reset) begin
      state     <= HUNT;
      q_valid   <= 1'b0;
      budget    <= '0;
      pay_cnt   <= '0;
      ptr       <= '0;
      acc       <= '0;
      tmo_cnt   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state     <= state_nxt;
      q_valid   <= rd_req;
      budget    <= budget_nxt;
      pay_cnt   <= pay_cnt_nxt;
      ptr       <= ptr_nxt;
      acc       <= acc_nxt;
      tmo_cnt   <= tmo_nxt;
      wr_en_q   <= wr_en_nxt;
      wr_addr_q <= wr_addr_nxt;
      wr_data_q <= wr_data_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
      code_q    <= code_nxt;
      cnt_q     <= cnt_nxt;
    end
  end

  // Requests are suppressed during reset so nothing is popped from the FIFO
  // and nothing returns in the first cycle after reset releases.
  assign bus.fifo_rdreq  = rd_req && !reset;
  assign bus.reg_wr_en   = wr_en_q;
  assign bus.reg_wr_addr = wr_addr_q;
  assign bus.reg_wr_data = wr_data_q;
  assign bus.pkt_done    = done_q;
  assign bus.pkt_err     = err_q;
  assign bus.err_code    = code_q;
  assign bus.pkt_count   = cnt_q;

endmodule

// File: tb/tb_pipe_cmd_decoder.sv
module tb_pipe_cmd_decoder;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 16;

  typedef struct {
    int          kind;   // 0 write, 1 done, 2 error
    logic [7:0]  addr;
    logic [31:0] data;
    logic [2:0]  code;
    logic [15:0] cnt;
    int          cyc;
  } ev_t;

  logic okClk = 1'b0;
  logic reset = 1'b1;
  pipe_cmd_decoder_if bus();

  pipe_cmd_decoder #(.SYNC(SYNC), .TIMEOUT(TMO)) dut (
    .okClk(okClk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 okClk = ~okClk;

  // FIFO model, normal mode: data appears the cycle after the request.
  logic [31:0] mem [0:4095];
  logic [11:0] wp = '0;
  logic [11:0] rp = '0;
  logic [31:0] q_reg = '0;
  assign bus.fifo_empty = (wp == rp);
  assign bus.fifo_q     = q_reg;

  always @(posedge okClk) begin
    if (bus.fifo_rdreq && (wp != rp)) begin
      q_reg <= mem[rp];
      rp    <= rp + 12'd1;
    end
  end

  int cyc = 0;
  always @(posedge okClk) cyc <= cyc + 1;

  // Monitor: records every pulse seen on the outputs.
  ev_t obs[$];
  int  overlap = 0;
  always @(negedge okClk) begin
    ev_t e;
    if ((int'(bus.reg_wr_en) + int'(bus.pkt_done) + int'(bus.pkt_err)) > 1)
      overlap = overlap + 1;
    e.addr = bus.reg_wr_addr; e.data = bus.reg_wr_data; e.code = bus.err_code;
    e.cnt = bus.pkt_count; e.cyc = cyc; e.kind = -1;
    if (bus.reg_wr_en) e.kind = 0;
    else if (bus.pkt_done) e.kind = 1;
    else if (bus.pkt_err) e.kind = 2;
    if (e.kind >= 0) obs.push_back(e);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int obs_base = 0;
  ev_t exp_q[$];
  logic [31:0] stream[$];
  logic [15:0] good_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wp] = w;
    wp = wp + 12'd1;
    stream.push_back(w);
  endtask

  task automatic add_exp(input int kind, input logic [7:0] a, input logic [31:0] d,
                         input logic [2:0] c, input logic [15:0] n);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d; e.code = c; e.cnt = n; e.cyc = 0;
    exp_q.push_back(e);
  endtask

  // Reference: walk the word stream with the packet rules.
  task automatic model_stream();
    int i = 0;
    logic [31:0] h, x, w;
    logic [7:0]  a;
    int n;
    while (i < stream.size()) begin
      h = stream[i]; i++;
      if (h[31:24] != SYNC) add_exp(2, 0, 0, 3'd1, 0);
      else if (h[7:0] == 8'd0) add_exp(2, 0, 0, 3'd2, 0);
      else begin
        n = int'(h[7:0]); x = h; a = h[23:16];
        for (int k = 0; k < n; k++) begin
          w = stream[i]; i++;
          add_exp(0, a, w, 0, 0);
          a = a + 8'd1;
          x = x ^ w;
        end
        w = stream[i]; i++;
        if (w == x) begin
          good_cnt = good_cnt + 16'd1;
          add_exp(1, 0, 0, 0, good_cnt);
        end else add_exp(2, 0, 0, 3'd3, 0);
      end
    end
    stream.delete();
  endtask

  task automatic run_check(input string tag);
    int got, m;
    for (int c = 0; c < 4000; c++) begin
      if ((obs.size() - obs_base) >= exp_q.size() && bus.fifo_empty) break;
      @(negedge okClk);
    end
    repeat (4) @(negedge okClk);
    got = obs.size() - obs_base;
    chk({tag, "_events"}, 64'(got), 64'(exp_q.size()));
    m = (got < exp_q.size()) ? got : exp_q.size();
    for (int i = 0; i < m; i++) begin
      ev_t o;
      o = obs[obs_base + i];
      chk({tag, "_kind"}, 64'(o.kind), 64'(exp_q[i].kind));
      if (exp_q[i].kind == 0) begin
        chk({tag, "_addr"}, 64'(o.addr), 64'(exp_q[i].addr));
        chk({tag, "_data"}, 64'(o.data), 64'(exp_q[i].data));
      end else if (exp_q[i].kind == 1) begin
        chk({tag, "_count"}, 64'(o.cnt), 64'(exp_q[i].cnt));
      end else begin
        chk({tag, "_code"}, 64'(o.code), 64'(exp_q[i].code));
      end
    end
    obs_base = obs_base + got;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdreq"}, 64'(bus.fifo_rdreq), 0);
    chk({tag, "_wr_en"}, 64'(bus.reg_wr_en), 0);
    chk({tag, "_wr_addr"}, 64'(bus.reg_wr_addr), 0);
    chk({tag, "_wr_data"}, 64'(bus.reg_wr_data), 0);
    chk({tag, "_done"}, 64'(bus.pkt_done), 0);
    chk({tag, "_err"}, 64'(bus.pkt_err), 0);
    chk({tag, "_err_code"}, 64'(bus.err_code), 0);
    chk({tag, "_pkt_count"}, 64'(bus.pkt_count), 0);
  endtask

  task automatic push_good();
    push(32'hA5100002); push(32'h00000001); push(32'h00000002); push(32'hA5100001);
  endtask

  initial begin
    int b;
    logic [31:0] h, x, w;
    int n, kind;

    // Reset state
    repeat (3) @(negedge okClk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge okClk);

    // Good packet, preloaded so writes come back to back
    b = obs_base;
    push_good();
    model_stream();
    run_check("good");
    if (obs.size() > b + 1)
      chk("good_b2b", 64'(obs[b + 1].cyc - obs[b].cyc), 1);
    chk("good_pkt_count", 64'(bus.pkt_count), 64'(good_cnt));

    // Bad checksum
    push(32'hA5100002); push(32'h00000001); push(32'h00000002); push(32'h00000000);
    model_stream();
    run_check("badsum");
    chk("badsum_pkt_count", 64'(bus.pkt_count), 64'(good_cnt));

    // Resync on garbage, then a good packet; error code is held
    push(32'h12345678);
    push_good();
    model_stream();
    run_check("resync");
    chk("resync_code_held", 64'(bus.err_code), 1);

    // Address wrap
    push(32'hA5FF0002); push(32'h0000000A); push(32'h0000000B); push(32'hA5FF0003);
    model_stream();
    run_check("wrap");

    // Timeout after one payload word
    b = obs_base;
    push(32'hA5200003); push(32'h00000111);
    stream.delete();
    add_exp(0, 8'h20, 32'h00000111, 0, 0);
    add_exp(2, 0, 0, 3'd4, 0);
    repeat (TMO + 10) @(negedge okClk);
    run_check("timeout");
    if (obs.size() > b + 1)
      chk("timeout_gap", 64'(obs[b + 1].cyc - obs[b].cyc), 64'(TMO));
    push_good();
    model_stream();
    run_check("after_tmo");

    // Reset mid-packet after the first payload write
    push(32'hA5300003); push(32'h00000055);
    stream.delete();
    add_exp(0, 8'h30, 32'h00000055, 0, 0);
    run_check("midrst_pre");
    reset = 1'b1;
    @(negedge okClk);
    check_reset_outputs("midrst");
    @(negedge okClk);
    reset = 1'b0;
    good_cnt = '0;
    repeat (TMO + 14) @(negedge okClk);
    chk("midrst_no_pulse", 64'(obs.size() - obs_base), 0);
    chk("midrst_code", 64'(bus.err_code), 0);
    push_good();
    model_stream();
    run_check("after_rst");

    // Randomized packet mix with irregular arrival
    for (int p = 0; p < 24; p++) begin
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        w = $urandom;
        if (w[31:24] == SYNC) w[31:24] = ~SYNC;
        push(w);
      end else if (kind == 1) begin
        w = $urandom;
        push({SYNC, w[23:8], 8'h00});
      end else begin
        n = $urandom_range(1, 8);
        h = $urandom;
        h = {SYNC, h[23:8], 8'(n)};
        x = h;
        push(h);
        for (int k = 0; k < n; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge okClk);
          w = $urandom;
          x = x ^ w;
          push(w);
        end
        if (kind == 2) x = x ^ ($urandom | 32'd1);
        push(x);
      end
      repeat ($urandom_range(0, 3)) @(negedge okClk);
    end
    model_stream();
    run_check("random");
    chk("random_pkt_count", 64'(bus.pkt_count), 64'(good_cnt));
    chk("exclusive_pulses", 64'(overlap), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
